// File: rtl/sha_256_arbiter.sv
// sha_256_arbiter
// Shares one sha_256_accelerator core among N_REQ requesters. A round-robin
// grant picks one pending 512-bit block, the block is issued to the core,
// and the 256-bit result (or a timeout error) goes back to the winner.
// After every job the core is reset before the next grant.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   ena                 global enable; low freezes all state and blanks pulses
//   req_valid/req_data  per-requester pending flag and block (i at [i*512 +: 512])
//   req_ready           one-hot accept pulse (S_ISSUE)
//   rsp_valid           one-hot result pulse (S_RESPOND)
//   rsp_hash/rsp_error  registered result; error = timeout with zero hash
//   busy                high whenever the FSM is not in S_IDLE
//   core_*              sole driver of the core inputs, and the core result

module sha_256_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ*512-1:0] req_data,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [255:0]         rsp_hash,
    output logic                 rsp_error,
    output logic                 busy,
    output logic                 core_rst,
    output logic                 core_ena,
    output logic [511:0]         core_input_data,
    output logic                 core_input_valid,
    input  logic [255:0]         core_output_hash,
    input  logic                 core_output_valid
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_CORE_RST = 3'd0,
        S_IDLE     = 3'd1,
        S_ISSUE    = 3'd2,
        S_WAIT     = 3'd3,
        S_RESPOND  = 3'd4,
        S_CLEAR    = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   grant_q, grant_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic            first_wait_q, first_wait_d;
    logic [255:0]    rsp_hash_q, rsp_hash_d;
    logic            rsp_error_q, rsp_error_d;
    logic [511:0]    core_data_q, core_data_d;

    logic            found_s;
    logic [PW-1:0]   pick_s;
    logic [511:0]    pick_blk_s;

    // Round-robin search: first pending requester above rr_ptr, then wrap to 0..rr_ptr.
    always_comb begin
        found_s    = 1'b0;
        pick_s     = rr_ptr_q;
        pick_blk_s = {512{1'b0}};
        for (int j = 0; j < N_REQ; j++) begin
            if (!found_s && req_valid[j] && (PW'(j) > rr_ptr_q)) begin
                found_s    = 1'b1;
                pick_s     = PW'(j);
                pick_blk_s = req_data[j*512 +: 512];
            end else begin
                found_s = found_s;
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (!found_s && req_valid[j] && (PW'(j) <= rr_ptr_q)) begin
                found_s    = 1'b1;
                pick_s     = PW'(j);
                pick_blk_s = req_data[j*512 +: 512];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state and datapath updates; everything holds while ena is low.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        tmo_cnt_d    = tmo_cnt_q;
        first_wait_d = first_wait_q;
        rsp_hash_d   = rsp_hash_q;
        rsp_error_d  = rsp_error_q;
        core_data_d  = core_data_q;
        if (ena) begin
            case (state_q)
                S_CORE_RST: state_d = S_IDLE;
                S_IDLE: begin
                    if (found_s) begin
                        grant_d     = pick_s;
                        rr_ptr_d    = pick_s;
                        core_data_d = pick_blk_s;
                        state_d     = S_ISSUE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_ISSUE: begin
                    tmo_cnt_d    = {TW{1'b0}};
                    first_wait_d = 1'b1;
                    state_d      = S_WAIT;
                end
                S_WAIT: begin
                    first_wait_d = 1'b0;
                    // The core's valid flag is still stale during the first wait cycle.
                    if (!first_wait_q && core_output_valid) begin
                        rsp_hash_d  = core_output_hash;
                        rsp_error_d = 1'b0;
                        state_d     = S_RESPOND;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        rsp_hash_d  = 256'd0;
                        rsp_error_d = 1'b1;
                        state_d     = S_RESPOND;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + TW'(1);
                    end
                end
                S_RESPOND: state_d = S_CLEAR;
                S_CLEAR:   state_d = S_IDLE;
                default:   state_d = S_CORE_RST;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Pulses decode straight from the state register so that ena can blank
    // them in the very cycle it drops.
    always_comb begin
        req_ready        = {N_REQ{1'b0}};
        rsp_valid        = {N_REQ{1'b0}};
        core_input_valid = 1'b0;
        core_rst         = 1'b0;
        if (ena) begin
            case (state_q)
                S_CORE_RST: core_rst = 1'b1;
                S_ISSUE: begin
                    req_ready        = ONE_HOT0 << grant_q;
                    core_input_valid = 1'b1;
                end
                S_RESPOND: rsp_valid = ONE_HOT0 << grant_q;
                S_CLEAR:   core_rst  = 1'b1;
                default:   core_rst  = 1'b0;
            endcase
        end else begin
            core_rst = 1'b0;
        end
    end

    assign busy            = (state_q != S_IDLE);
    assign core_ena        = ena;
    assign rsp_hash        = rsp_hash_q;
    assign rsp_error       = rsp_error_q;
    assign core_input_data = core_data_q;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_CORE_RST;
            grant_q      <= {PW{1'b0}};
            rr_ptr_q     <= PW'(N_REQ - 1);
            tmo_cnt_q    <= {TW{1'b0}};
            first_wait_q <= 1'b0;
            rsp_hash_q   <= 256'd0;
            rsp_error_q  <= 1'b0;
            core_data_q  <= 512'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            tmo_cnt_q    <= tmo_cnt_d;
            first_wait_q <= first_wait_d;
            rsp_hash_q   <= rsp_hash_d;
            rsp_error_q  <= rsp_error_d;
            core_data_q  <= core_data_d;
        end
    end

endmodule

// File: tb/tb_sha_256_arbiter.sv
// Directed bench for sha_256_arbiter with a small behavioural core model.
module tb_sha_256_arbiter;
    localparam int N_REQ       = 4;
    localparam int TIMEOUT_CYC = 255;
    localparam int LAT         = 3;
    localparam logic [511:0] ABC_BLOCK  = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [255:0] ABC_HASH   =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] STALE_HASH =
        256'hdeadbeefdeadbeefdeadbeefdeadbeefdeadbeefdeadbeefdeadbeefdeadbeef;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 ena;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ*512-1:0] req_data;
    logic [N_REQ-1:0]     req_ready;
    logic [N_REQ-1:0]     rsp_valid;
    logic [255:0]         rsp_hash;
    logic                 rsp_error;
    logic                 busy;
    logic                 core_rst;
    logic                 core_ena;
    logic [511:0]         core_input_data;
    logic                 core_input_valid;
    logic [255:0]         core_output_hash;
    logic                 core_output_valid;

    sha_256_arbiter #(.N_REQ(N_REQ), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rst(rst), .ena(ena),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_hash(rsp_hash), .rsp_error(rsp_error),
        .busy(busy), .core_rst(core_rst), .core_ena(core_ena),
        .core_input_data(core_input_data), .core_input_valid(core_input_valid),
        .core_output_hash(core_output_hash), .core_output_valid(core_output_valid)
    );

    always #5 clk = ~clk;

    // Core model: fixed latency, result held until core_rst. The digest of
    // the "abc" block is the real SHA-256 value; other blocks use a simple fold.
    function automatic logic [255:0] core_fn(input logic [511:0] d);
        if (d == ABC_BLOCK) return ABC_HASH;
        else return d[511:256] ^ {d[127:0], d[255:128]};
    endfunction

    function automatic logic [511:0] make_block(input int seed);
        logic [511:0] b;
        for (int w = 0; w < 16; w++) b[w*32 +: 32] = 32'hA5000000 | 32'(seed * 16 + w);
        return b;
    endfunction

    logic         never_valid = 1'b0;
    logic         stale_req   = 1'b0;
    logic         stale_pend  = 1'b0;
    logic         stale_done  = 1'b0;
    logic         cm_valid    = 1'b0;
    logic         cm_busy     = 1'b0;
    int           cm_cnt      = 0;
    logic [255:0] cm_hash     = 256'd0;
    logic         stale_act;

    assign stale_act         = stale_req & ~stale_done;
    assign core_output_valid = stale_act | cm_valid;
    assign core_output_hash  = stale_act ? STALE_HASH : cm_hash;

    always @(posedge clk) begin
        if (core_ena) begin
            if (core_rst) begin
                cm_valid <= 1'b0;
                cm_busy  <= 1'b0;
                cm_cnt   <= 0;
            end else if (core_input_valid) begin
                cm_hash  <= core_fn(core_input_data);
                cm_busy  <= 1'b1;
                cm_cnt   <= LAT;
                cm_valid <= 1'b0;
            end else if (cm_busy && cm_cnt == 1) begin
                cm_busy  <= 1'b0;
                cm_valid <= !never_valid;
            end else if (cm_busy) begin
                cm_cnt <= cm_cnt - 1;
            end
        end
    end

    // Stale flag stays up through the issue cycle and the first wait cycle.
    always @(posedge clk) begin
        if (!stale_req) begin
            stale_pend <= 1'b0;
            stale_done <= 1'b0;
        end else if (core_ena) begin
            if (core_input_valid) stale_pend <= 1'b1;
            else if (stale_pend) begin
                stale_done <= 1'b1;
                stale_pend <= 1'b0;
            end
        end
    end

    // Output monitor, sampled on the falling edge.
    int           cyc = 0, rsp_pulses = 0, ready_pulses = 0, issue_pulses = 0;
    int           onehot_bad = 0, ena_bad = 0, issue_cyc = 0, rsp_cyc = 0;
    logic [N_REQ-1:0] last_vec = '0;
    logic [255:0] last_hash = 256'd0;
    logic         last_err = 1'b0;
    int           rsp_by [N_REQ] = '{default: 0};
    logic [255:0] hash_by [N_REQ] = '{default: 256'd0};
    int           grant_log [$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (core_input_valid) begin
            issue_pulses <= issue_pulses + 1;
            issue_cyc    <= cyc;
        end
        if (rsp_valid != '0) begin
            rsp_pulses <= rsp_pulses + 1;
            rsp_cyc    <= cyc;
            last_vec   <= rsp_valid;
            last_hash  <= rsp_hash;
            last_err   <= rsp_error;
            if ($countones(rsp_valid) != 1) onehot_bad <= onehot_bad + 1;
            for (int i = 0; i < N_REQ; i++)
                if (rsp_valid[i]) begin
                    rsp_by[i]  <= rsp_by[i] + 1;
                    hash_by[i] <= rsp_hash;
                end
        end
        if (req_ready != '0) begin
            ready_pulses <= ready_pulses + 1;
            if ($countones(req_ready) != 1) onehot_bad <= onehot_bad + 1;
            for (int i = 0; i < N_REQ; i++) if (req_ready[i]) grant_log.push_back(i);
        end
        if (!ena && (req_ready != '0 || rsp_valid != '0 || core_input_valid || core_rst))
            ena_bad <= ena_bad + 1;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; a requester drops its request once it sees its accept pulse.
    task automatic tick();
        @(posedge clk);
        #1;
        if (req_ready != '0) req_valid = req_valid & ~req_ready;
    endtask

    task automatic wait_rsp(input int target, input int budget, input string tag);
        int n = 0;
        while (rsp_pulses < target && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_done"}, 512'(rsp_pulses >= target), 512'd1);
    endtask

    task automatic wait_issue(input int budget, input string tag);
        int n = 0;
        while (core_input_valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_issue"}, 512'(core_input_valid), 512'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
    endtask

    int r0, q0, i0, g0, e0;
    int rb [N_REQ];
    logic [511:0] blk;

    initial begin
        rst = 1'b1; ena = 1'b1; req_valid = '0; req_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_core_rst", 512'(core_rst), 512'd1);
        check("rst_req_ready", 512'(req_ready), 512'd0);
        check("rst_rsp_valid", 512'(rsp_valid), 512'd0);
        check("rst_rsp_hash", 512'(rsp_hash), 512'd0);
        check("rst_rsp_error", 512'(rsp_error), 512'd0);
        check("rst_core_data", core_input_data, 512'd0);
        check("rst_core_ivalid", 512'(core_input_valid), 512'd0);
        rst = 1'b0;
        check("rel_core_rst", 512'(core_rst), 512'd1);
        tick();
        check("idle_core_rst", 512'(core_rst), 512'd0);
        check("idle_busy", 512'(busy), 512'd0);

        // 1: single "abc" job from requester 0
        req_data[0 +: 512] = ABC_BLOCK;
        r0 = rsp_pulses; q0 = ready_pulses; g0 = grant_log.size();
        req_valid = 4'b0001;
        wait_rsp(r0 + 1, 50, "t1");
        check("t1_vec", 512'(last_vec), 512'(4'b0001));
        check("t1_err", 512'(last_err), 512'd0);
        check("t1_hash", 512'(last_hash), 512'(ABC_HASH));
        check("t1_ready_cnt", 512'(ready_pulses - q0), 512'd1);
        check("t1_grant", 512'(grant_log[g0]), 512'd0);
        check("t1_latency", 512'(rsp_cyc - issue_cyc), 512'(LAT + 2));
        check("t1_core_data", core_input_data, ABC_BLOCK);
        tick();
        check("t1_idle_busy", 512'(busy), 512'd0);

        // 2: all four pending after reset -> grants 0,1,2,3
        do_reset();
        for (int i = 0; i < N_REQ; i++) req_data[i*512 +: 512] = make_block(i + 1);
        r0 = rsp_pulses; g0 = grant_log.size(); e0 = onehot_bad;
        for (int i = 0; i < N_REQ; i++) rb[i] = rsp_by[i];
        req_valid = 4'b1111;
        tick();
        check("t2_busy", 512'(busy), 512'd1);
        wait_rsp(r0 + 4, 200, "t2");
        check("t2_grant_cnt", 512'(grant_log.size() - g0), 512'd4);
        for (int i = 0; i < N_REQ; i++) begin
            check($sformatf("t2_grant%0d", i), 512'(grant_log[g0 + i]), 512'(i));
            check($sformatf("t2_rsp_cnt%0d", i), 512'(rsp_by[i] - rb[i]), 512'd1);
            check($sformatf("t2_hash%0d", i), 512'(hash_by[i]), 512'(core_fn(make_block(i + 1))));
        end
        check("t2_onehot", 512'(onehot_bad - e0), 512'd0);
        tick();

        // 3: core never answers -> timeout on requester 2, then a normal job
        never_valid = 1'b1;
        req_data[2*512 +: 512] = make_block(9);
        r0 = rsp_pulses;
        req_valid = 4'b0100;
        wait_rsp(r0 + 1, 400, "t3");
        check("t3_vec", 512'(last_vec), 512'(4'b0100));
        check("t3_err", 512'(last_err), 512'd1);
        check("t3_hash", 512'(last_hash), 512'd0);
        check("t3_latency", 512'(rsp_cyc - issue_cyc), 512'(TIMEOUT_CYC + 1));
        never_valid = 1'b0;
        tick();
        blk = make_block(10);
        req_data[2*512 +: 512] = blk;
        r0 = rsp_pulses;
        req_valid = 4'b0100;
        wait_rsp(r0 + 1, 50, "t3b");
        check("t3b_err", 512'(last_err), 512'd0);
        check("t3b_hash", 512'(last_hash), 512'(core_fn(blk)));
        tick();

        // 4: reset in the middle of a wait from requester 1
        req_data[1*512 +: 512] = make_block(11);
        req_valid = 4'b0010;
        wait_issue(20, "t4");
        tick();
        tick();
        r0 = rsp_pulses;
        rst = 1'b1;
        #1;
        check("t4_core_rst", 512'(core_rst), 512'd1);
        check("t4_rsp_valid", 512'(rsp_valid), 512'd0);
        check("t4_rsp_hash", 512'(rsp_hash), 512'd0);
        check("t4_core_data", core_input_data, 512'd0);
        check("t4_core_ivalid", 512'(core_input_valid), 512'd0);
        req_valid = '0;
        repeat (5) tick();
        check("t4_no_rsp", 512'(rsp_pulses - r0), 512'd0);
        rst = 1'b0;
        check("t4_rel_core_rst", 512'(core_rst), 512'd1);
        tick();
        check("t4_core_rst_low", 512'(core_rst), 512'd0);
        blk = make_block(12);
        req_data[1*512 +: 512] = blk;
        r0 = rsp_pulses; g0 = grant_log.size();
        req_valid = 4'b0010;
        wait_rsp(r0 + 1, 50, "t4b");
        check("t4b_vec", 512'(last_vec), 512'(4'b0010));
        check("t4b_grant", 512'(grant_log[g0]), 512'd1);
        check("t4b_hash", 512'(last_hash), 512'(core_fn(blk)));
        tick();

        // 5: ena low for 10 cycles in S_ISSUE and again in S_WAIT
        blk = make_block(13);
        req_data[3*512 +: 512] = blk;
        r0 = rsp_pulses; q0 = ready_pulses; i0 = issue_pulses; e0 = ena_bad;
        req_valid = 4'b1000;
        wait_issue(20, "t5");
        ena = 1'b0;
        #1;
        check("t5_ready_blank", 512'(req_ready), 512'd0);
        check("t5_ivalid_blank", 512'(core_input_valid), 512'd0);
        repeat (10) tick();
        ena = 1'b1;
        #1;
        check("t5_ivalid_back", 512'(core_input_valid), 512'd1);
        check("t5_ready_back", 512'(req_ready), 512'(4'b1000));
        tick();
        tick();
        ena = 1'b0;
        repeat (10) tick();
        ena = 1'b1;
        wait_rsp(r0 + 1, 60, "t5");
        check("t5_issue_cnt", 512'(issue_pulses - i0), 512'd1);
        check("t5_ready_cnt", 512'(ready_pulses - q0), 512'd1);
        check("t5_no_pulse_off", 512'(ena_bad - e0), 512'd0);
        check("t5_latency", 512'(rsp_cyc - issue_cyc), 512'(LAT + 2 + 10));
        check("t5_vec", 512'(last_vec), 512'(4'b1000));
        check("t5_hash", 512'(last_hash), 512'(core_fn(blk)));
        tick();

        // 6: stale core_output_valid during S_ISSUE and the first wait cycle
        blk = make_block(14);
        req_data[0 +: 512] = blk;
        r0 = rsp_pulses;
        stale_req = 1'b1;
        req_valid = 4'b0001;
        wait_rsp(r0 + 1, 50, "t6");
        check("t6_vec", 512'(last_vec), 512'(4'b0001));
        check("t6_err", 512'(last_err), 512'd0);
        check("t6_hash", 512'(last_hash), 512'(core_fn(blk)));
        check("t6_latency", 512'(rsp_cyc - issue_cyc), 512'(LAT + 2));
        stale_req = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
